control_flow_unit: RTL and testbench
====================================

Name: control_flow_unit

Overview:
- Produces the redirect controls consumed by the fetch unit: branch, jump, branch_addr, jump_target and halted.
- Decodes each fetched instruction together with its PC and the ALU zero flag.
- Issues single-cycle redirect pulses and squashes wrong-path instructions for a fixed number of cycles after each redirect.
- Latches a sticky halt.
- Sits between instruction memory/decode and fetch_unit, closing the PC loop.

Parameters:
- FLUSH_CYCLES, 2, number of cycles after a redirect pulse during which instr_valid is ignored; legal range 1..7.
- PC_W, 10, PC and target width.
- INSTR_W, 16, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instr/instr_pc hold a fetched instruction this cycle.
- instr  input  16  instruction word.
- instr_pc  input  10  PC of instr.
- cond_zero  input  1  ALU zero flag, sampled with instr.
- branch  output  1  one-cycle pulse: fetch loads branch_addr.
- branch_addr  output  10  branch target.
- jump  output  1  one-cycle pulse: fetch loads jump_target.
- jump_target  output  10  jump target.
- halted  output  1  sticky halt to fetch.
- flush  output  1  high while wrong-path instructions are squashed.
- taken_count  output  8  count of redirects issued, wraps 255->0.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0: branch, jump, branch_addr, jump_target, halted, flush, taken_count.
  - State is RUN; flush counter is 0.
- Decode, opcode = instr[15:12]:
  - 4'hF HALT.
  - 4'hE JMP: target = instr[9:0].
  - 4'hD BZ: taken when cond_zero=1.
  - 4'hC BNZ: taken when cond_zero=0.
  - All other opcodes produce no action.
- Branch target arithmetic:
  - branch_addr = instr_pc + 1 + sext(instr[7:0]) to 10 bits, modulo 1024.
  - Wrap is legal and silent, e.g. pc 1023, imm 0 -> 0; pc 0, imm -1 -> 0; pc 0, imm -2 -> 1023.
- Outputs are registered. A qualifying instruction accepted on edge N produces its output during the cycle after edge N (1-cycle latency).
- branch and jump are single-cycle pulses and are never high together.
- branch_addr and jump_target hold their last loaded value between pulses.
- Untaken BZ/BNZ: no pulse, no flush, no count. branch_addr is not updated.
- States:
  - RUN:
    - Accept instr when instr_valid=1.
    - HALT -> HALTED.
    - JMP or taken branch -> pulse, taken_count+1, -> FLUSH with counter = FLUSH_CYCLES.
    - Else stay in RUN.
  - FLUSH:
    - flush=1; instr_valid and instr are ignored, including HALT/JMP.
    - Counter decrements each cycle; at 1 -> RUN.
    - flush is high for exactly FLUSH_CYCLES cycles, beginning in the same cycle as the pulse.
  - HALTED:
    - halted=1 from the cycle after HALT is accepted, until reset.
    - No further pulses, flush=0, taken_count frozen, all inputs ignored.
- Priority within one accepted instruction: HALT > JMP > branch. The opcode is unique, so this only matters for state: halt wins over any pending flush entry.
- instr_valid=0 in RUN: no action, state held.
- Reset asserted mid-FLUSH or in HALTED: immediate return to RUN with all outputs 0. Any in-progress pulse is cancelled in the same cycle.

Test Plan:
- Reset then JMP: reset 2 cycles, then instr=16'hE155, valid, pc=5 -> next cycle jump=1, jump_target=10'h155, flush=1 for 2 cycles, taken_count=1. Valid instrs during flush produce no pulse.
- Taken BZ with wrap: instr=16'hD0FE (imm -2), pc=0, cond_zero=1 -> branch=1, branch_addr=1023. A separate case, pc=1023, imm=0, gives branch_addr=0.
- Untaken branches: BZ with cond_zero=0, then BNZ with cond_zero=1 -> no branch pulse, flush=0, taken_count unchanged, branch_addr holds previous value.
- Halt: HALT 16'hF000 valid -> halted=1 next cycle and stays high for 10 cycles. A subsequent JMP and taken BZ produce no pulse; taken_count frozen.
- Squashed halt: JMP, then HALT presented in the first flush cycle -> halted stays 0. A HALT presented after flush ends -> halted=1.
- Async reset mid-flush: assert reset between edges during FLUSH -> flush, jump, halted and taken_count go 0 immediately, before the next edge. After release, a JMP is accepted normally; with FLUSH_CYCLES=1 re-run, flush is high for 1 cycle.

Source files
------------

// File: rtl/control_flow_unit.sv
// control_flow_unit
// Decodes fetched instructions against the ALU zero flag and drives the
// redirect controls for fetch: single-cycle branch/jump pulses with their
// targets, a wrong-path squash window after every redirect, and a sticky halt.
`timescale 1ns/1ps

module control_flow_unit #(
  parameter int FLUSH_CYCLES = 2,   // squash window length, 1..7
  parameter int PC_W         = 10,
  parameter int INSTR_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    instr_pc,
  input  logic               cond_zero,
  output logic               branch,
  output logic [PC_W-1:0]    branch_addr,
  output logic               jump,
  output logic [PC_W-1:0]    jump_target,
  output logic               halted,
  output logic               flush,
  output logic [7:0]         taken_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_BNZ  = 4'hC;

  // Flush window length as loaded into the 3-bit down-counter.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  // Architectural state
  state_t            r_state;
  logic [2:0]        r_flush_cnt;
  logic              r_branch;
  logic              r_jump;
  logic [PC_W-1:0]   r_branch_addr;
  logic [PC_W-1:0]   r_jump_target;
  logic [7:0]        r_taken_count;

  // Next-state values
  state_t            w_state_next;
  logic [2:0]        w_flush_cnt_next;
  logic              w_branch_next;
  logic              w_jump_next;
  logic [PC_W-1:0]   w_branch_addr_next;
  logic [PC_W-1:0]   w_jump_target_next;
  logic [7:0]        w_taken_count_next;

  // Decode
  logic [3:0]        w_opcode;
  logic              w_is_halt;
  logic              w_is_jmp;
  logic              w_br_taken;
  logic [PC_W-1:0]   w_imm_sext;
  logic [PC_W-1:0]   w_branch_tgt;
  logic [PC_W-1:0]   w_jmp_tgt;
  logic              w_unused_instr_bits;

  assign w_opcode   = instr[INSTR_W-1 -: 4];
  assign w_is_halt  = (w_opcode == OP_HALT);
  assign w_is_jmp   = (w_opcode == OP_JMP);
  assign w_br_taken = ((w_opcode == OP_BZ)  &&  cond_zero) ||
                      ((w_opcode == OP_BNZ) && !cond_zero);

  // PC-relative target: pc + 1 + sign-extended 8-bit offset, wrapping mod 2^PC_W.
  assign w_imm_sext   = {{(PC_W-8){instr[7]}}, instr[7:0]};
  assign w_branch_tgt = instr_pc + PC_W'(1) + w_imm_sext;
  assign w_jmp_tgt    = instr[PC_W-1:0];

  // Bits between the opcode and the jump field carry no meaning here.
  assign w_unused_instr_bits = ^instr;

  // Next-state and registered-output computation for the RUN/FLUSH/HALTED FSM.
  always_comb begin
    w_state_next       = r_state;
    w_flush_cnt_next   = r_flush_cnt;
    w_branch_next      = 1'b0;
    w_jump_next        = 1'b0;
    w_branch_addr_next = r_branch_addr;
    w_jump_target_next = r_jump_target;
    w_taken_count_next = r_taken_count;

    case (r_state)
      ST_RUN: begin
        if (instr_valid) begin
          if (w_is_halt) begin
            w_state_next = ST_HALTED;
          end else if (w_is_jmp) begin
            w_jump_next        = 1'b1;
            w_jump_target_next = w_jmp_tgt;
            w_taken_count_next = r_taken_count + 8'd1;
            w_state_next       = ST_FLUSH;
            w_flush_cnt_next   = FLUSH_INIT;
          end else if (w_br_taken) begin
            w_branch_next      = 1'b1;
            w_branch_addr_next = w_branch_tgt;
            w_taken_count_next = r_taken_count + 8'd1;
            w_state_next       = ST_FLUSH;
            w_flush_cnt_next   = FLUSH_INIT;
          end
        end
      end

      ST_FLUSH: begin
        // Inputs are wrong-path here; only the window counter advances.
        if (r_flush_cnt <= 3'd1) begin
          w_state_next     = ST_RUN;
          w_flush_cnt_next = 3'd0;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
        end
      end

      ST_HALTED: begin
        // Sticky until reset; everything frozen.
      end

      default: begin
        w_state_next     = ST_RUN;
        w_flush_cnt_next = 3'd0;
      end
    endcase
  end

  // State and output registers; reset cancels any pulse immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_flush_cnt   <= 3'd0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_branch_addr <= '0;
      r_jump_target <= '0;
      r_taken_count <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_flush_cnt   <= w_flush_cnt_next;
      r_branch      <= w_branch_next;
      r_jump        <= w_jump_next;
      r_branch_addr <= w_branch_addr_next;
      r_jump_target <= w_jump_target_next;
      r_taken_count <= w_taken_count_next;
    end
  end

  assign branch      = r_branch;
  assign jump        = r_jump;
  assign branch_addr = r_branch_addr;
  assign jump_target = r_jump_target;
  assign taken_count = r_taken_count;
  assign flush       = (r_state == ST_FLUSH);
  assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_control_flow_unit.sv
// Scoreboard bench for control_flow_unit: expected redirects are queued as
// stimulus is issued; a negedge monitor pops and compares on every pulse.
`timescale 1ns/1ps

module tb_control_flow_unit;

  typedef struct {
    logic       is_jump;
    logic [9:0] addr;
    logic [7:0] count;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        cond_zero;

  logic        branch, jump, halted, flush;
  logic [9:0]  branch_addr, jump_target;
  logic [7:0]  taken_count;

  logic        b1_branch, b1_jump, b1_halted, b1_flush;
  logic [9:0]  b1_branch_addr, b1_jump_target;
  logic [7:0]  b1_taken_count;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  control_flow_unit #(.FLUSH_CYCLES(2), .PC_W(10), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .cond_zero(cond_zero),
    .branch(branch), .branch_addr(branch_addr), .jump(jump),
    .jump_target(jump_target), .halted(halted), .flush(flush),
    .taken_count(taken_count)
  );

  control_flow_unit #(.FLUSH_CYCLES(1), .PC_W(10), .INSTR_W(16)) dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .cond_zero(cond_zero),
    .branch(b1_branch), .branch_addr(b1_branch_addr), .jump(b1_jump),
    .jump_target(b1_jump_target), .halted(b1_halted), .flush(b1_flush),
    .taken_count(b1_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic present(input logic v, input logic [15:0] ins, input logic [9:0] pc, input logic cz);
    instr_valid = v;
    instr       = ins;
    instr_pc    = pc;
    cond_zero   = cz;
  endtask

  task automatic push(input logic is_j, input logic [9:0] addr, input logic [7:0] cnt);
    exp_t e;
    e.is_jump = is_j;
    e.addr    = addr;
    e.count   = cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: one compare set per redirect pulse seen on the default instance.
  always @(negedge clk) begin
    if (branch && jump)
      check("pulse_exclusive", 32'(branch & jump), 32'd0);
    if (branch || jump) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got branch=%0b jump=%0b, expected no pulse", branch, jump);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] pulse %s addr=0x%0h count=%0d (exp %s 0x%0h %0d)",
                 jump ? "jump" : "branch", jump ? jump_target : branch_addr, taken_count,
                 mon_e.is_jump ? "jump" : "branch", mon_e.addr, mon_e.count);
        check("pulse_kind", 32'(jump), 32'(mon_e.is_jump));
        check("pulse_addr", 32'(jump ? jump_target : branch_addr), 32'(mon_e.addr));
        check("pulse_count", 32'(taken_count), 32'(mon_e.count));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_jump", 32'(jump), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_count", 32'(taken_count), 32'd0);
    check("rst_addrs", 32'({branch_addr, jump_target}), 32'd0);
    tick();
    reset = 1'b0;

    // JMP, with valid instructions offered during the flush window
    present(1'b1, 16'hE155, 10'd5, 1'b0);
    push(1'b1, 10'h155, 8'd1);
    tick();
    check("jmp_flush_c1", 32'(flush), 32'd1);
    present(1'b1, 16'hE0AA, 10'd6, 1'b0);
    tick();
    check("jmp_flush_c2", 32'(flush), 32'd1);
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    check("jmp_flush_end", 32'(flush), 32'd0);
    check("jmp_count_hold", 32'(taken_count), 32'd1);

    // Taken BZ wrapping below zero, then wrapping above 1023
    present(1'b1, 16'hD0FE, 10'd0, 1'b1);
    push(1'b0, 10'd1023, 8'd2);
    tick();
    check("bz_wrap_flush", 32'(flush), 32'd1);
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    tick();
    present(1'b1, 16'hD000, 10'd1023, 1'b1);
    push(1'b0, 10'd0, 8'd3);
    tick();
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    tick();

    // Untaken BZ, untaken BNZ, and a no-op opcode
    present(1'b1, 16'hD012, 10'd7, 1'b0);
    tick();
    check("bz_nt_flush", 32'(flush), 32'd0);
    check("bz_nt_addr", 32'(branch_addr), 32'd0);
    check("bz_nt_count", 32'(taken_count), 32'd3);
    present(1'b1, 16'hC034, 10'd8, 1'b1);
    tick();
    check("bnz_nt_flush", 32'(flush), 32'd0);
    check("bnz_nt_addr", 32'(branch_addr), 32'd0);
    check("bnz_nt_count", 32'(taken_count), 32'd3);
    present(1'b1, 16'h1234, 10'd9, 1'b1);
    tick();
    check("nop_flush", 32'(flush), 32'd0);
    check("nop_count", 32'(taken_count), 32'd3);

    // Taken BNZ: 0x10 + 1 + 3 = 0x14
    present(1'b1, 16'hC003, 10'h010, 1'b0);
    push(1'b0, 10'h014, 8'd4);
    tick();
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    tick();

    // JMP leaves branch_addr alone
    present(1'b1, 16'hE3FF, 10'd0, 1'b0);
    push(1'b1, 10'h3FF, 8'd5);
    tick();
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    tick();
    check("jmp_baddr_hold", 32'(branch_addr), 32'h014);

    // JMP on the bus without instr_valid
    present(1'b0, 16'hE001, 10'd0, 1'b0);
    tick();
    check("novalid_flush", 32'(flush), 32'd0);
    check("novalid_count", 32'(taken_count), 32'd5);

    // HALT in the first flush cycle is squashed
    present(1'b1, 16'hE001, 10'd0, 1'b0);
    push(1'b1, 10'h001, 8'd6);
    tick();
    present(1'b1, 16'hF000, 10'd0, 1'b0);
    tick();
    check("sq_halt_c1", 32'(halted), 32'd0);
    check("sq_halt_flush", 32'(flush), 32'd1);
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    check("sq_halt_c2", 32'(halted), 32'd0);
    check("sq_flush_end", 32'(flush), 32'd0);

    // HALT after the window is accepted and sticks
    present(1'b1, 16'hF000, 10'd0, 1'b0);
    tick();
    check("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) present(1'b1, 16'hE155, 10'd5, 1'b1);
      else            present(1'b1, 16'hD0FE, 10'd5, 1'b1);
      tick();
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_noflush", 32'(flush), 32'd0);
      check("halt_count", 32'(taken_count), 32'd6);
    end

    // Async reset while halted
    #2 reset = 1'b1;
    #1;
    check("areset_halted", 32'(halted), 32'd0);
    check("areset_count", 32'(taken_count), 32'd0);
    check("areset_addrs", 32'({branch_addr, jump_target}), 32'd0);
    tick();
    reset = 1'b0;

    // Async reset mid-flush, during the jump pulse
    present(1'b1, 16'hE100, 10'd0, 1'b0);
    push(1'b1, 10'h100, 8'd1);
    tick();
    check("mid_flush_pre", 32'(flush), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_flush", 32'(flush), 32'd0);
    check("mid_rst_jump", 32'(jump), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_count", 32'(taken_count), 32'd0);
    check("mid_rst_target", 32'(jump_target), 32'd0);
    tick();
    reset = 1'b0;

    // JMP after reset; FLUSH_CYCLES=1 instance runs alongside
    present(1'b1, 16'hE2AB, 10'd3, 1'b0);
    push(1'b1, 10'h2AB, 8'd1);
    tick();
    check("post_flush_c1", 32'(flush), 32'd1);
    check("fc1_jump", 32'(b1_jump), 32'd1);
    check("fc1_target", 32'(b1_jump_target), 32'h2AB);
    check("fc1_count", 32'(b1_taken_count), 32'd1);
    check("fc1_flush_c1", 32'(b1_flush), 32'd1);
    present(1'b0, 16'h0000, 10'd0, 1'b0);
    tick();
    check("post_flush_c2", 32'(flush), 32'd1);
    check("fc1_flush_c2", 32'(b1_flush), 32'd0);
    tick();
    check("post_flush_end", 32'(flush), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
